shift_arb: RTL and testbench

- Two-requester round-robin arbiter and 2-stage pipeline around one shared 32-bit barrel shifter (`shift_mux`: d, sa, right, arith -> sh).
- Accepts shift operations over per-requester valid/grant handshakes and issues one operation per cycle to the shifter.
- Returns registered results tagged with the requester id over a valid/ready output port.
- Sits between the ALU-side requesters (e.g. integer shift unit, address/immediate formatter) and their result consumers.

---
 rtl/shift_arb.sv | 208 ++++++++++++++++++++
 tb/tb_shift_arb.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_arb.sv
// shift_arb: two-requester round-robin arbiter feeding a shared 32-bit
// barrel shifter through a two-stage pipeline (operand stage S1, result
// stage S2). Results leave over a valid/ready port tagged with the id of
// the requester that issued them.

// shift_mux: combinational 32-bit barrel shifter.
// Left shifts are performed as right shifts on the bit-reversed operand,
// so a single log-shifter serves all three modes.
module shift_mux (
  input  logic [31:0] d,
  input  logic [4:0]  sa,
  input  logic        right,
  input  logic        arith,
  output logic [31:0] sh
);

  logic [31:0]      rev_in;
  logic [5:0][31:0] stage;
  logic             fill;

  // Sign fill only applies to arithmetic right shifts; left and logical
  // right shifts bring in zeros.
  assign fill = right & arith & d[31];

  // Reverse the operand for left shifts so the stages only shift right.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_rev_in
      assign rev_in[gi] = right ? d[gi] : d[31-gi];
    end
  endgenerate

  assign stage[0] = rev_in;

  // Log shifter: stage gi shifts right by 2**gi when sa[gi] is set.
  generate
    for (gi = 0; gi < 5; gi++) begin : g_stage
      localparam int STEP = 1 << gi;
      assign stage[gi+1] = sa[gi] ? {{STEP{fill}}, stage[gi][31:STEP]}
                                  : stage[gi];
    end
  endgenerate

  // Undo the reversal for left shifts.
  generate
    for (gi = 0; gi < 32; gi++) begin : g_rev_out
      assign sh[gi] = right ? stage[5][gi] : stage[5][31-gi];
    end
  endgenerate

endmodule

module shift_arb #(
  parameter logic PRIO_RST = 1'b0
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        req0,
  input  logic [31:0] d0,
  input  logic [4:0]  sa0,
  input  logic        right0,
  input  logic        arith0,
  output logic        gnt0,
  input  logic        req1,
  input  logic [31:0] d1,
  input  logic [4:0]  sa1,
  input  logic        right1,
  input  logic        arith1,
  output logic        gnt1,
  output logic        vld,
  output logic [31:0] sh,
  output logic        id,
  input  logic        rdy
);

  // Round-robin pointer: index of the requester favoured on a tie.
  logic        ptr_reg;
  logic        ptr_next;

  // Stage 1: granted operands waiting for the shifter.
  logic        s1_vld_reg;
  logic [31:0] s1_d_reg;
  logic [4:0]  s1_sa_reg;
  logic        s1_right_reg;
  logic        s1_arith_reg;
  logic        s1_id_reg;

  // Stage 2: registered result presented on the output port.
  logic        vld_reg;
  logic [31:0] sh_reg;
  logic        id_reg;

  logic        stall;
  logic        accept;
  logic [1:0]  req_vec;
  logic [1:0]  gnt_vec;
  logic        any_gnt;
  logic        gnt_id;
  logic [31:0] sel_d;
  logic [4:0]  sel_sa;
  logic        sel_right;
  logic        sel_arith;
  logic [31:0] shift_res;

  // A held result blocks both pipeline stages, so new work is only taken
  // when the output is empty or being drained this cycle. Grants are also
  // suppressed while reset is asserted.
  assign stall   = vld_reg & ~rdy;
  assign accept  = ~stall & ~clr;
  assign req_vec = {req1, req0};

  // Grant selection: a lone requester wins outright, a tie goes to ptr.
  always_comb begin
    gnt_vec = 2'b00;
    if (accept) begin
      case (req_vec)
        2'b01:   gnt_vec = 2'b01;
        2'b10:   gnt_vec = 2'b10;
        2'b11:   gnt_vec = ptr_reg ? 2'b10 : 2'b01;
        default: gnt_vec = 2'b00;
      endcase
    end
  end

  assign gnt0    = gnt_vec[0];
  assign gnt1    = gnt_vec[1];
  assign any_gnt = |gnt_vec;
  assign gnt_id  = gnt_vec[1];

  // After any grant the other requester becomes favoured; otherwise hold.
  always_comb begin
    ptr_next = ptr_reg;
    if (gnt_vec[0]) begin
      ptr_next = 1'b1;
    end else if (gnt_vec[1]) begin
      ptr_next = 1'b0;
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_d     = gnt_id ? d1     : d0;
    sel_sa    = gnt_id ? sa1    : sa0;
    sel_right = gnt_id ? right1 : right0;
    sel_arith = gnt_id ? arith1 : arith0;
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ptr_reg <= PRIO_RST;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

  // Stage 1: load the granted operation, empty when nothing is granted,
  // hold everything while the output is stalled.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      s1_vld_reg   <= 1'b0;
      s1_d_reg     <= 32'd0;
      s1_sa_reg    <= 5'd0;
      s1_right_reg <= 1'b0;
      s1_arith_reg <= 1'b0;
      s1_id_reg    <= 1'b0;
    end else if (!stall) begin
      s1_vld_reg <= any_gnt;
      if (any_gnt) begin
        s1_d_reg     <= sel_d;
        s1_sa_reg    <= sel_sa;
        s1_right_reg <= sel_right;
        s1_arith_reg <= sel_arith;
        s1_id_reg    <= gnt_id;
      end
    end
  end

  // Single shared shifter, driven straight from stage 1.
  shift_mux u_shift_mux (
    .d     (s1_d_reg),
    .sa    (s1_sa_reg),
    .right (s1_right_reg),
    .arith (s1_arith_reg),
    .sh    (shift_res)
  );

  // Stage 2: capture the shifter result; data only updates when stage 1
  // actually held an operation so an idle cycle leaves sh/id unchanged.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      vld_reg <= 1'b0;
      sh_reg  <= 32'd0;
      id_reg  <= 1'b0;
    end else if (!stall) begin
      vld_reg <= s1_vld_reg;
      if (s1_vld_reg) begin
        sh_reg <= shift_res;
        id_reg <= s1_id_reg;
      end
    end
  end

  assign vld = vld_reg;
  assign sh  = sh_reg;
  assign id  = id_reg;

endmodule

// File: tb/tb_shift_arb.sv
// tb_shift_arb: directed vector table, a reset-in-flight sequence and a
// randomized run checked against a queue-based reference model.
module tb_shift_arb;

  logic        clk = 1'b0;
  logic        clr;
  logic        req0, req1;
  logic [31:0] d0, d1;
  logic [4:0]  sa0, sa1;
  logic        right0, right1, arith0, arith1;
  logic        gnt0, gnt1;
  logic        vld;
  logic [31:0] sh;
  logic        id;
  logic        rdy;

  int total = 0;
  int bad   = 0;

  shift_arb #(.PRIO_RST(1'b0)) dut (
    .clk(clk), .clr(clr),
    .req0(req0), .d0(d0), .sa0(sa0), .right0(right0), .arith0(arith0), .gnt0(gnt0),
    .req1(req1), .d1(d1), .sa1(sa1), .right1(right1), .arith1(arith1), .gnt1(gnt1),
    .vld(vld), .sh(sh), .id(id), .rdy(rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference shift written from the arithmetic definition of each mode.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] sa,
                                            input logic right, input logic arith);
    if (!right)     return d << sa;
    else if (arith) return 32'($signed(d) >>> sa);
    else            return d >> sa;
  endfunction

  typedef struct {
    logic        r0; logic [31:0] d0; logic [4:0] s0; logic rt0; logic ar0;
    logic        r1; logic [31:0] d1; logic [4:0] s1; logic rt1; logic ar1;
    logic        rdy;
    logic        g0; logic g1; logic v; logic [31:0] sh; logic id;
  } vec_t;

  function automatic vec_t mk(
    input logic r0, input logic [31:0] dd0, input logic [4:0] s0, input logic rt0, input logic ar0,
    input logic r1, input logic [31:0] dd1, input logic [4:0] s1, input logic rt1, input logic ar1,
    input logic rd, input logic g0, input logic g1, input logic v, input logic [31:0] esh, input logic eid);
    vec_t t;
    t.r0 = r0; t.d0 = dd0; t.s0 = s0; t.rt0 = rt0; t.ar0 = ar0;
    t.r1 = r1; t.d1 = dd1; t.s1 = s1; t.rt1 = rt1; t.ar1 = ar1;
    t.rdy = rd; t.g0 = g0; t.g1 = g1; t.v = v; t.sh = esh; t.id = eid;
    return t;
  endfunction

  function automatic vec_t idle(input logic rd, input logic v, input logic [31:0] esh, input logic eid);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rd, 0, 0, v, esh, eid);
  endfunction

  vec_t tbl[29];

  // Reference model state for the random run.
  typedef struct { logic [31:0] sh; logic id; int age; } pend_t;
  pend_t       q[$];
  logic        mptr;
  logic        have[2];
  logic [31:0] pd[2];
  logic [4:0]  psa[2];
  logic        prt[2];
  logic        par[2];

  task automatic drive_idle();
    req0 = 0; d0 = 0; sa0 = 0; right0 = 0; arith0 = 0;
    req1 = 0; d1 = 0; sa1 = 0; right1 = 0; arith1 = 0;
  endtask

  initial begin
    clr = 1'b1;
    rdy = 1'b1;
    drive_idle();
    req0 = 1'b1;

    // Reset state, with a request pending that must not be granted.
    #12;
    chk("rst_vld", {31'd0, vld}, 32'd0);
    chk("rst_sh", sh, 32'd0);
    chk("rst_id", {31'd0, id}, 32'd0);
    chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
    req0 = 1'b0;
    clr = 1'b0;
    @(posedge clk); #1;

    // ---------------- directed vector table ----------------
    tbl[0]  = mk(1, 32'hff0000ff, 8, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    tbl[1]  = idle(1, 0, 0, 0);
    tbl[2]  = idle(1, 1, 32'h0000ff00, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 1, 32'hff0000ff, 8, 1, 0, 1, 0, 1, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 1, 32'hff0000ff, 8, 1, 1, 1, 0, 1, 0, 0, 0);
    tbl[5]  = idle(1, 1, 32'h00ff0000, 1);
    tbl[6]  = idle(1, 1, 32'hffff0000, 1);
    tbl[7]  = mk(1, 1, 1, 0, 0, 1, 1, 2, 0, 0, 1, 1, 0, 0, 0, 0);
    tbl[8]  = mk(1, 1, 3, 0, 0, 1, 1, 2, 0, 0, 1, 0, 1, 0, 0, 0);
    tbl[9]  = mk(1, 1, 3, 0, 0, 1, 1, 4, 0, 0, 1, 1, 0, 1, 2, 0);
    tbl[10] = mk(1, 1, 5, 0, 0, 1, 1, 4, 0, 0, 1, 0, 1, 1, 4, 1);
    tbl[11] = idle(1, 1, 8, 0);
    tbl[12] = idle(1, 1, 16, 1);
    tbl[13] = idle(1, 0, 0, 0);
    tbl[14] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    tbl[15] = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    tbl[16] = mk(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    tbl[17] = mk(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    tbl[18] = mk(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    tbl[19] = mk(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 0);
    tbl[20] = mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 2, 0);
    tbl[21] = idle(1, 1, 4, 0);
    tbl[22] = idle(1, 1, 8, 0);
    tbl[23] = idle(1, 0, 0, 0);
    tbl[24] = mk(0, 0, 0, 0, 0, 1, 32'hff0000ff, 0, 1, 1, 1, 0, 1, 0, 0, 0);
    tbl[25] = mk(0, 0, 0, 0, 0, 1, 32'h80000000, 31, 1, 1, 1, 0, 1, 0, 0, 0);
    tbl[26] = idle(1, 1, 32'hff0000ff, 1);
    tbl[27] = idle(1, 1, 32'hffffffff, 1);
    tbl[28] = idle(1, 0, 0, 0);

    for (int i = 0; i < 29; i++) begin
      req0 = tbl[i].r0; d0 = tbl[i].d0; sa0 = tbl[i].s0; right0 = tbl[i].rt0; arith0 = tbl[i].ar0;
      req1 = tbl[i].r1; d1 = tbl[i].d1; sa1 = tbl[i].s1; right1 = tbl[i].rt1; arith1 = tbl[i].ar1;
      rdy  = tbl[i].rdy;
      #1;
      chk($sformatf("vec%0d_gnt0", i), {31'd0, gnt0}, {31'd0, tbl[i].g0});
      chk($sformatf("vec%0d_gnt1", i), {31'd0, gnt1}, {31'd0, tbl[i].g1});
      chk($sformatf("vec%0d_vld", i), {31'd0, vld}, {31'd0, tbl[i].v});
      if (tbl[i].v) begin
        chk($sformatf("vec%0d_sh", i), sh, tbl[i].sh);
        chk($sformatf("vec%0d_id", i), {31'd0, id}, {31'd0, tbl[i].id});
      end
      $display("vec %0d: gnt=%b%b vld=%b sh=%h id=%b", i, gnt1, gnt0, vld, sh, id);
      @(posedge clk); #1;
    end

    // ---------------- reset with both stages full ----------------
    drive_idle();
    rdy = 1'b1;
    req0 = 1; d0 = 32'h3; sa0 = 4;
    #1 chk("rmid_gntA", {31'd0, gnt0}, 32'd1);
    @(posedge clk); #1;
    d0 = 32'h3; sa0 = 8;
    #1 chk("rmid_gntB", {31'd0, gnt0}, 32'd1);
    @(posedge clk); #1;
    d0 = 32'h5; sa0 = 12;
    #1 chk("rmid_pre_vld", {31'd0, vld}, 32'd1);
    clr = 1'b1;
    #1;
    chk("rmid_vld", {31'd0, vld}, 32'd0);
    chk("rmid_sh", sh, 32'd0);
    chk("rmid_id", {31'd0, id}, 32'd0);
    chk("rmid_gnt0", {31'd0, gnt0}, 32'd0);
    $display("reset mid-op: vld=%b sh=%h", vld, sh);
    @(posedge clk); #1;
    chk("rmid_hold_vld", {31'd0, vld}, 32'd0);
    #1 clr = 1'b0;
    req1 = 1; d1 = 32'h9; sa1 = 1;
    #1;
    chk("rmid_tie_gnt0", {31'd0, gnt0}, 32'd1);
    chk("rmid_tie_gnt1", {31'd0, gnt1}, 32'd0);
    @(posedge clk); #1;
    drive_idle();
    #1 chk("rmid_s1_vld", {31'd0, vld}, 32'd0);
    @(posedge clk); #1;
    chk("rmid_res_vld", {31'd0, vld}, 32'd1);
    chk("rmid_res_sh", sh, 32'h00005000);
    chk("rmid_res_id", {31'd0, id}, 32'd0);
    $display("after reset: sh=%h id=%b", sh, id);
    @(posedge clk); #1;
    chk("rmid_noreplay", {31'd0, vld}, 32'd0);

    // ---------------- randomized run against the model ----------------
    clr = 1'b1;
    #2 clr = 1'b0;
    @(posedge clk); #1;
    q.delete();
    mptr = 1'b0;
    for (int r = 0; r < 2; r++) begin
      have[r] = 0; pd[r] = 0; psa[r] = 0; prt[r] = 0; par[r] = 0;
    end

    for (int c = 0; c < 600; c++) begin
      logic mvld, mstall, eg0, eg1;
      for (int r = 0; r < 2; r++) begin
        if (have[r] && $urandom_range(0, 99) < 4) have[r] = 0;
        if (!have[r] && $urandom_range(0, 99) < 60) begin
          have[r] = 1;
          pd[r]   = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
          case ($urandom_range(0, 9))
            0:       psa[r] = 5'd0;
            1:       psa[r] = 5'd31;
            default: psa[r] = 5'($urandom_range(0, 31));
          endcase
          prt[r] = 1'($urandom_range(0, 1));
          par[r] = 1'($urandom_range(0, 1));
        end
      end
      req0 = have[0]; d0 = pd[0]; sa0 = psa[0]; right0 = prt[0]; arith0 = par[0];
      req1 = have[1]; d1 = pd[1]; sa1 = psa[1]; right1 = prt[1]; arith1 = par[1];
      rdy  = ($urandom_range(0, 99) < 70);
      #1;
      mvld   = (q.size() > 0) && (q[0].age >= 2);
      mstall = mvld & ~rdy;
      eg0    = !mstall && have[0] && (!have[1] || mptr == 1'b0);
      eg1    = !mstall && have[1] && !eg0;
      chk("rnd_gnt0", {31'd0, gnt0}, {31'd0, eg0});
      chk("rnd_gnt1", {31'd0, gnt1}, {31'd0, eg1});
      chk("rnd_vld", {31'd0, vld}, {31'd0, mvld});
      if (mvld) begin
        chk("rnd_sh", sh, q[0].sh);
        chk("rnd_id", {31'd0, id}, {31'd0, q[0].id});
        if (rdy) $display("rnd cycle %0d: result id=%b sh=%h", c, id, sh);
      end
      @(posedge clk);
      if (!mstall) begin
        if (mvld) void'(q.pop_front());
        foreach (q[k]) q[k].age++;
        if (eg0 || eg1) begin
          pend_t e;
          int    g;
          g     = eg1 ? 1 : 0;
          e.sh  = ref_shift(pd[g], psa[g], prt[g], par[g]);
          e.id  = eg1;
          e.age = 1;
          q.push_back(e);
          have[g] = 0;
          mptr    = eg0 ? 1'b1 : 1'b0;
        end
      end
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
